// File: rtl/key_debounce_pkg.sv
// Shared device constants for the key peripheral: register offsets, key count
// and the read-word packing helpers used by the bridge-facing logic.
package key_debounce_pkg;

  localparam int NUM_KEYS = 8;

  localparam logic ADDR_STATUS = 1'b0;
  localparam logic ADDR_IEN    = 1'b1;

  typedef logic [NUM_KEYS-1:0] key_vec_t;

  function automatic logic [31:0] status_word(input key_vec_t ev, input key_vec_t st);
    return {16'b0, ev, st};
  endfunction

  function automatic logic [31:0] ien_word(input key_vec_t ien);
    return {24'b0, ien};
  endfunction

endpackage

// File: rtl/key_debounce_filter.sv
// Single-key filter: 2-flop synchronizer, saturating-free debounce counter,
// accepted (stable) level and a combinational press pulse on acceptance.
module key_filter #(
  parameter int DEBOUNCE_MAX = 500000,
  parameter int CNT_W        = 20
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_n_i,
  output logic stable_o,
  output logic press_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_MAX - 1);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stable_q, stable_d;
  logic             sync_lvl;
  logic             mismatch;
  logic             accept;

  // Synchronized level, inverted so that 1 means pressed.
  assign sync_lvl = ~sync_q[1];

  always_comb begin
    mismatch = sync_lvl ^ stable_q;
    accept   = mismatch && (cnt_q == CNT_LAST);
    cnt_d    = (mismatch && !accept) ? cnt_q + CNT_W'(1) : '0;
    stable_d = accept ? sync_lvl : stable_q;
    press_o  = accept && sync_lvl;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q   <= '1;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], key_n_i};
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/key_debounce.sv
// Eight-key debounce peripheral: per-key filters, sticky press events with
// write-1-to-clear, interrupt enable register and a registered interrupt.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int DEBOUNCE_MAX = 500000,
  parameter int CNT_W        = 20
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] user_key,
  input  logic                addr,
  input  logic                we,
  input  logic [31:0]         in,
  output logic [31:0]         out,
  output logic                int_req
);

  key_vec_t stable;
  key_vec_t press;
  key_vec_t event_q, event_d;
  key_vec_t ien_q, ien_d;
  key_vec_t clr_mask;
  logic     int_req_q;
  logic     unused_in_hi;

  genvar g;
  for (g = 0; g < NUM_KEYS; g++) begin : g_key
    key_filter #(
      .DEBOUNCE_MAX(DEBOUNCE_MAX),
      .CNT_W       (CNT_W)
    ) u_filter (
      .clk_i   (clk),
      .rst_i   (reset),
      .key_n_i (user_key[g]),
      .stable_o(stable[g]),
      .press_o (press[g])
    );
  end

  assign unused_in_hi = ^in[31:2*NUM_KEYS];

  // Press is OR-ed in after the clear so a same-edge set beats W1C.
  always_comb begin
    clr_mask = (we && addr == ADDR_STATUS) ? in[2*NUM_KEYS-1:NUM_KEYS] : '0;
    event_d  = (event_q & ~clr_mask) | press;
    ien_d    = (we && addr == ADDR_IEN) ? in[NUM_KEYS-1:0] : ien_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      event_q   <= '0;
      ien_q     <= '0;
      int_req_q <= 1'b0;
    end else begin
      event_q   <= event_d;
      ien_q     <= ien_d;
      int_req_q <= |(event_q & ien_q);
    end
  end

  always_comb begin
    out = (addr == ADDR_IEN) ? ien_word(ien_q) : status_word(event_q, stable);
  end

  assign int_req = int_req_q;

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with DEBOUNCE_MAX=4 (acceptance 6 edges after sampling).
module tb_key_debounce;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  user_key = 8'hFF;
  logic        addr = 1'b0;
  logic        we = 1'b0;
  logic [31:0] in = 32'h0;
  logic [31:0] out;
  logic        int_req;

  int n_checks = 0;
  int n_errors = 0;

  key_debounce #(
    .DEBOUNCE_MAX(4),
    .CNT_W       (20)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .user_key(user_key),
    .addr    (addr),
    .we      (we),
    .in      (in),
    .out     (out),
    .int_req (int_req)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    user_key = 8'hFF;
    step(3);
    reset = 1'b0;
    addr = 1'b0;
    #1;
    n_checks++;
    if (out !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_status: got %h expected %h", out, 32'h0);
    end
    addr = 1'b1;
    #1;
    n_checks++;
    if (out !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_ien: got %h expected %h", out, 32'h0);
    end
    n_checks++;
    if (int_req !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_int_req: got %b expected 0", int_req);
    end
    addr = 1'b0;
  endtask

  task automatic test_press();
    user_key = 8'hFE;
    step(5);
    n_checks++;
    if (out !== 32'h0) begin
      n_errors++;
      $display("FAIL press_edge5: got %h expected %h", out, 32'h0);
    end
    step(1);
    n_checks++;
    if (out !== 32'h0000_0101) begin
      n_errors++;
      $display("FAIL press_edge6: got %h expected %h", out, 32'h0000_0101);
    end
    user_key = 8'hFF;
    step(6);
    n_checks++;
    if (out !== 32'h0000_0100) begin
      n_errors++;
      $display("FAIL release_keeps_event: got %h expected %h", out, 32'h0000_0100);
    end
    we = 1'b1; addr = 1'b0; in = 32'h0000_0100;
    step(1);
    we = 1'b0; in = 32'h0;
    n_checks++;
    if (out !== 32'h0) begin
      n_errors++;
      $display("FAIL w1c_event0: got %h expected %h", out, 32'h0);
    end
  endtask

  task automatic test_glitch();
    user_key = 8'hFD;
    step(3);
    user_key = 8'hFF;
    step(1);
    n_checks++;
    if (out !== 32'h0) begin
      n_errors++;
      $display("FAIL glitch3_early: got %h expected %h", out, 32'h0);
    end
    step(10);
    n_checks++;
    if (out !== 32'h0) begin
      n_errors++;
      $display("FAIL glitch3_late: got %h expected %h", out, 32'h0);
    end
    // Four sampled cycles low is exactly enough to be accepted.
    user_key = 8'hFD;
    step(4);
    user_key = 8'hFF;
    step(2);
    n_checks++;
    if (out !== 32'h0000_0202) begin
      n_errors++;
      $display("FAIL pulse4_accept: got %h expected %h", out, 32'h0000_0202);
    end
    step(8);
    we = 1'b1; in = 32'h0000_0200;
    step(1);
    we = 1'b0; in = 32'h0;
    n_checks++;
    if (out !== 32'h0) begin
      n_errors++;
      $display("FAIL pulse4_release_clear: got %h expected %h", out, 32'h0);
    end
  endtask

  task automatic test_irq();
    we = 1'b1; addr = 1'b1; in = 32'hFFFF_FF01;
    step(1);
    we = 1'b0; in = 32'h0;
    n_checks++;
    if (out !== 32'h0000_0001) begin
      n_errors++;
      $display("FAIL ien_read: got %h expected %h", out, 32'h0000_0001);
    end
    addr = 1'b0;
    user_key = 8'hFE;
    step(6);
    n_checks++;
    if (out !== 32'h0000_0101 || int_req !== 1'b0) begin
      n_errors++;
      $display("FAIL irq_event_edge: got out=%h int_req=%b expected out=%h int_req=0",
               out, int_req, 32'h0000_0101);
    end
    step(1);
    n_checks++;
    if (int_req !== 1'b1) begin
      n_errors++;
      $display("FAIL irq_assert: got %b expected 1", int_req);
    end
    we = 1'b1; in = 32'h0000_0100;
    step(1);
    we = 1'b0; in = 32'h0;
    n_checks++;
    if (out !== 32'h0000_0001 || int_req !== 1'b1) begin
      n_errors++;
      $display("FAIL irq_clear_edge: got out=%h int_req=%b expected out=%h int_req=1",
               out, int_req, 32'h0000_0001);
    end
    step(1);
    n_checks++;
    if (int_req !== 1'b0) begin
      n_errors++;
      $display("FAIL irq_deassert: got %b expected 0", int_req);
    end
    user_key = 8'hFF;
    step(6);
    // Pending event, enable toggled afterwards.
    we = 1'b1; addr = 1'b1; in = 32'h0;
    step(1);
    we = 1'b0; addr = 1'b0;
    user_key = 8'hFE;
    step(8);
    n_checks++;
    if (out !== 32'h0000_0101 || int_req !== 1'b0) begin
      n_errors++;
      $display("FAIL irq_masked: got out=%h int_req=%b expected out=%h int_req=0",
               out, int_req, 32'h0000_0101);
    end
    we = 1'b1; addr = 1'b1; in = 32'h0000_0001;
    step(1);
    we = 1'b0; in = 32'h0;
    n_checks++;
    if (int_req !== 1'b0) begin
      n_errors++;
      $display("FAIL ien_set_same_edge: got %b expected 0", int_req);
    end
    step(1);
    n_checks++;
    if (int_req !== 1'b1) begin
      n_errors++;
      $display("FAIL ien_set_next_edge: got %b expected 1", int_req);
    end
    we = 1'b1; in = 32'h0;
    step(1);
    we = 1'b0;
    n_checks++;
    if (int_req !== 1'b1) begin
      n_errors++;
      $display("FAIL ien_clr_same_edge: got %b expected 1", int_req);
    end
    step(1);
    n_checks++;
    if (int_req !== 1'b0) begin
      n_errors++;
      $display("FAIL ien_clr_next_edge: got %b expected 0", int_req);
    end
    addr = 1'b0;
    user_key = 8'hFF;
    we = 1'b1; in = 32'h0000_FF00;
    step(1);
    we = 1'b0; in = 32'h0;
    step(6);
    n_checks++;
    if (out !== 32'h0) begin
      n_errors++;
      $display("FAIL irq_cleanup: got %h expected %h", out, 32'h0);
    end
  endtask

  task automatic test_back_to_back();
    addr = 1'b0;
    user_key = 8'hFB;
    step(5);
    we = 1'b1; in = 32'h0000_0400;
    step(1);
    we = 1'b0; in = 32'h0;
    n_checks++;
    if (out !== 32'h0000_0404) begin
      n_errors++;
      $display("FAIL set_beats_w1c: got %h expected %h", out, 32'h0000_0404);
    end
    we = 1'b1; in = 32'h0000_0400;
    step(1);
    we = 1'b0; in = 32'h0;
    n_checks++;
    if (out !== 32'h0000_0004) begin
      n_errors++;
      $display("FAIL w1c_after_set: got %h expected %h", out, 32'h0000_0004);
    end
    user_key = 8'hFF;
    step(6);
    n_checks++;
    if (out !== 32'h0) begin
      n_errors++;
      $display("FAIL release_key2: got %h expected %h", out, 32'h0);
    end
  endtask

  task automatic test_reset_mid();
    addr = 1'b0;
    user_key = 8'hF7;
    step(4);
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    n_checks++;
    if (out !== 32'h0) begin
      n_errors++;
      $display("FAIL mid_reset_clear: got %h expected %h", out, 32'h0);
    end
    step(5);
    n_checks++;
    if (out !== 32'h0) begin
      n_errors++;
      $display("FAIL mid_reset_edge5: got %h expected %h", out, 32'h0);
    end
    step(1);
    n_checks++;
    if (out !== 32'h0000_0808) begin
      n_errors++;
      $display("FAIL mid_reset_edge6: got %h expected %h", out, 32'h0000_0808);
    end
    user_key = 8'hFF;
  endtask

  initial begin
    test_reset();
    test_press();
    test_glitch();
    test_irq();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
